// File: rtl/trng_sample_buffer.sv
// Consumer of the TRNG byte stream: warm-up discard, repetition-count health test
// and a small show-ahead FIFO popped by the register block.
module trng_sample_buffer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int WARMUP_BYTES = 2,
  parameter int RCT_CUTOFF   = 8
) (
  input  logic                            clk_i,
  input  logic                            rstn_i,
  input  logic                            enable_i,
  output logic                            trng_en_o,
  input  logic [7:0]                      trng_data_i,
  input  logic                            trng_valid_i,
  input  logic                            rd_req_i,
  output logic [7:0]                      rd_data_o,
  output logic                            rd_valid_o,
  output logic [$clog2(FIFO_DEPTH):0]     level_o,
  output logic                            overrun_o,
  output logic                            health_fail_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam int WW = (WARMUP_BYTES > 0) ? $clog2(WARMUP_BYTES + 1) : 1;
  localparam int RW = $clog2(RCT_CUTOFF + 1);

  typedef enum logic [1:0] {ST_OFF, ST_WARMUP, ST_RUN, ST_FAIL} state_t;

  state_t          state_reg;
  logic [WW-1:0]   warm_cnt_reg;
  logic [7:0]      last_byte_reg;
  logic [RW-1:0]   rep_cnt_reg;
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [LW-1:0]   level_reg;
  logic            trng_en_reg;
  logic            overrun_reg;
  logic            health_fail_reg;
  logic [7:0]      mem [FIFO_DEPTH];

  logic            fifo_full;
  logic            fifo_empty;
  logic            run_strobe;
  logic            rep_match;
  logic [RW-1:0]   rep_cnt_next;
  logic            rct_trip;
  logic            push_req;
  logic            push;
  logic            pop;

  always_comb begin
    fifo_full    = (level_reg == LW'(FIFO_DEPTH));
    fifo_empty   = (level_reg == '0);
    run_strobe   = enable_i && (state_reg == ST_RUN) && trng_valid_i;
    // rep_cnt_reg == 0 marks "no byte seen yet in RUN", so the first strobe starts at 1.
    rep_match    = (rep_cnt_reg != '0) && (trng_data_i == last_byte_reg);
    rep_cnt_next = rep_match ? (rep_cnt_reg + RW'(1)) : RW'(1);
    rct_trip     = run_strobe && (rep_cnt_next == RW'(RCT_CUTOFF));
    push_req     = run_strobe && !rct_trip;
    pop          = enable_i && rd_req_i && !fifo_empty;
    push         = push_req && (!fifo_full || pop);
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_reg       <= ST_OFF;
      warm_cnt_reg    <= '0;
      last_byte_reg   <= '0;
      rep_cnt_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      trng_en_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      health_fail_reg <= 1'b0;
    end else if (!enable_i) begin
      state_reg       <= ST_OFF;
      warm_cnt_reg    <= '0;
      rep_cnt_reg     <= '0;
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      level_reg       <= '0;
      trng_en_reg     <= 1'b0;
      overrun_reg     <= 1'b0;
      health_fail_reg <= 1'b0;
    end else begin
      case (state_reg)
        ST_OFF: begin
          state_reg    <= (WARMUP_BYTES == 0) ? ST_RUN : ST_WARMUP;
          warm_cnt_reg <= WW'(WARMUP_BYTES);
          rep_cnt_reg  <= '0;
          trng_en_reg  <= 1'b1;
        end
        ST_WARMUP: begin
          if (trng_valid_i) begin
            warm_cnt_reg <= warm_cnt_reg - WW'(1);
            if (warm_cnt_reg == WW'(1)) state_reg <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (run_strobe) begin
            rep_cnt_reg   <= rep_cnt_next;
            last_byte_reg <= trng_data_i;
          end
          if (rct_trip) begin
            state_reg       <= ST_FAIL;
            trng_en_reg     <= 1'b0;
            health_fail_reg <= 1'b1;
          end
        end
        ST_FAIL: begin
          trng_en_reg <= 1'b0;
        end
        default: state_reg <= ST_OFF;
      endcase

      // A health failure flushes the buffer in the same edge as the failing strobe.
      if (rct_trip) begin
        wr_ptr_reg <= '0;
        rd_ptr_reg <= '0;
        level_reg  <= '0;
      end else begin
        if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
        if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
        if (push && !pop)      level_reg <= level_reg + LW'(1);
        else if (pop && !push) level_reg <= level_reg - LW'(1);
        if (push_req && fifo_full && !pop) overrun_reg <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_reg] <= trng_data_i;
  end

  assign trng_en_o     = trng_en_reg;
  assign rd_valid_o    = !fifo_empty;
  assign rd_data_o     = fifo_empty ? 8'h00 : mem[rd_ptr_reg];
  assign level_o       = level_reg;
  assign overrun_o     = overrun_reg;
  assign health_fail_o = health_fail_reg;

endmodule

// File: doc/trng_sample_buffer.md
# trng_sample_buffer

Consumer side of the TRNG byte stream (the 8-bit data plus valid strobe, with no back-pressure). It enables the generator and discards the first warm-up bytes. It runs a repetition-count health test on every byte and buffers accepted bytes in a small show-ahead FIFO. The CPU-facing register block pops bytes through a read-request handshake.

## Interface
Parameters:
- FIFO_DEPTH, 4: buffer entries; power of two, ≥ 2.
- WARMUP_BYTES, 2: bytes discarded after enable, before buffering starts; ≥ 0.
- RCT_CUTOFF, 8: number of identical consecutive bytes that triggers a health failure; ≥ 2.

Ports:
- clk_i, in, 1: clock.
- rstn_i, in, 1: reset, asynchronous, active-low.
- enable_i, in, 1: unit enable from control register. Low means flush, clear flags and go to OFF.
- trng_en_o, out, 1: enable to the generator; registered.
- trng_data_i, in, 8: random byte from the generator.
- trng_valid_i, in, 1: single-cycle strobe; trng_data_i is valid while it is high.
- rd_req_i, in, 1: pop request from the register block.
- rd_data_o, out, 8: FIFO head (show-ahead). Value is 0x00 when empty.
- rd_valid_o, out, 1: FIFO not empty.
- level_o, out, $clog2(FIFO_DEPTH)+1: current fill count.
- overrun_o, out, 1: sticky; a byte was dropped because the FIFO was full.
- health_fail_o, out, 1: sticky; the repetition-count test failed.

## Operation
- Reset value of every output is 0. All internal state resets to OFF, FIFO empty, counters 0.
- State machine (registered):
  - OFF: trng_en_o=0. Goes to WARMUP when enable_i=1.
  - WARMUP: trng_en_o=1. Each trng_valid_i decrements the warm-up counter and the byte is discarded. Goes to RUN after WARMUP_BYTES strobes, or immediately if WARMUP_BYTES=0.
  - RUN: trng_en_o=1. Bytes are health-tested and pushed to the FIFO.
  - FAIL: trng_en_o=0 and health_fail_o=1. The FIFO is flushed on entry and trng_valid_i is ignored.
  - From any state, enable_i=0 leads to OFF on the next edge. This flushes the FIFO and clears overrun_o, health_fail_o, the warm-up counter and the RCT counter.
- Repetition-count test (RUN only):
  - Keep last_byte and rep_cnt.
  - On a strobe: if the byte equals last_byte, rep_cnt+1; otherwise rep_cnt=1 and last_byte is updated.
  - If the new rep_cnt equals RCT_CUTOFF, go to FAIL. The failing byte is not pushed.
  - The first strobe in RUN always sets rep_cnt=1.
- FIFO push: happens on a strobe in RUN that does not fail the test. The push is dropped and overrun_o set if the FIFO is full and no pop happens in the same cycle.
- FIFO pop: happens when rd_req_i=1 and rd_valid_o=1. rd_req_i while empty is ignored.
- Simultaneous push and pop:
  - FIFO full: both happen, level unchanged, no overrun.
  - FIFO empty: only the push happens.
- Pointers are $clog2(FIFO_DEPTH) bits wide and wrap modulo FIFO_DEPTH. Full/empty are derived from level_o.

## Timing
- enable_i rising at edge N: state=WARMUP and trng_en_o=1 after edge N+1.
- Push at edge N: rd_valid_o, rd_data_o and level_o update after edge N. The byte is poppable in cycle N+1.
- Pop at edge N: the next head is shown after edge N. One pop per cycle is possible at full throughput.
- The failing strobe at edge N gives state=FAIL, trng_en_o=0, health_fail_o=1, level_o=0 and rd_valid_o=0, all after edge N.
- enable_i=0 sampled at edge N: all outputs are 0 after edge N.
- Asynchronous reset mid-operation: everything returns to 0 immediately. No byte is popped or retained.

## Test plan
- Warm-up: enable, then strobe bytes 0x11, 0x22, 0x33, 0x44. Required: only 0x33 and 0x44 are buffered (level_o=2); popping returns 0x33 then 0x44.
- Overrun: with rd_req_i=0, strobe 5 distinct bytes in RUN (depth 4). Required: level_o=4, overrun_o=1, and pops return the first 4 bytes in order.
- Full push+pop: with the FIFO full of 0xA0–0xA3, assert rd_req_i together with a 0xA4 strobe. Required: rd_data_o=0xA1, level_o=4, overrun_o=0.
- RCT: in RUN, send 0x5A eight times with 2 bytes already buffered. Required: the 8th strobe gives health_fail_o=1, trng_en_o=0, level_o=0. Further strobes are ignored.
- Recovery: from FAIL, drive enable_i=0 for 1 cycle, then 1. Required: flags clear, trng_en_o returns one cycle later, and warm-up is repeated.
- Reset: assert rstn_i low mid-stream with level_o=3. Required: all outputs are 0 asynchronously; after release, state is OFF.
